// File: rtl/ssp_pkg.sv
// Shared SSP definitions: controller state encoding, default word width and
// FIFO read/write strobe polarity, used by the transmit and receive controllers.
package ssp_pkg;

  localparam int SSP_WIDTH = 8;

  localparam logic FIFO_RW_READ  = 1'b0;
  localparam logic FIFO_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FRAME = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } ssp_state_e;

endpackage

// File: rtl/ssp_tick_gen.sv
// Serial bit-clock divider: counts DIV pclk cycles per half-period and tracks
// which half of the serial period is in progress (phase 0 = sclk high).
module ssp_tick_gen #(
  parameter int DIV = 1
) (
  input  logic pclk,
  input  logic clear,
  input  logic active,
  output logic half_tick,
  output logic period_end,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign half_tick  = active && (cnt == CW'(DIV - 1));
  assign period_end = half_tick && phase;

  always_ff @(posedge pclk or negedge clear) begin
    if (!clear) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!active) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (half_tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssp_tx_ctrl.sv
// SSP transmit controller: pops one word from the TX FIFO, sends a one-period
// frame sync, then shifts the word out MSB-first with a divided serial clock.
module ssp_tx_ctrl
  import ssp_pkg::*;
#(
  parameter int WIDTH = SSP_WIDTH,
  parameter int DIV   = 1
) (
  input  logic             pclk,
  input  logic             clear,
  input  logic             ssp_en,
  input  logic             fifo_nempty,
  input  logic [WIDTH-1:0] fifo_word,
  output logic             fifo_en,
  output logic             fifo_rw,
  output logic             sclk,
  output logic             fss,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ssp_state_e       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bitcnt, bitcnt_nxt;
  logic             active, half_tick, period_end, phase, last_bit, serial_nxt;

  assign active     = (state == ST_FRAME) || (state == ST_SHIFT);
  assign last_bit   = (bitcnt == BW'(WIDTH - 1));
  assign serial_nxt = (state_nxt == ST_FRAME) || (state_nxt == ST_SHIFT);
  assign fifo_rw    = FIFO_RW_READ;

  ssp_tick_gen #(.DIV(DIV)) u_tick (
    .pclk       (pclk),
    .clear      (clear),
    .active     (active),
    .half_tick  (half_tick),
    .period_end (period_end),
    .phase      (phase)
  );

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    case (state)
      ST_IDLE:  if (ssp_en && fifo_nempty) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_LOAD;
      ST_LOAD: begin
        shreg_nxt  = fifo_word;
        bitcnt_nxt = '0;
        state_nxt  = ST_FRAME;
      end
      ST_FRAME: if (period_end) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (period_end) begin
          shreg_nxt = shreg << 1;
          if (last_bit) state_nxt = ST_DONE;
          else          bitcnt_nxt = bitcnt + 1'b1;
        end
      end
      ST_DONE:  state_nxt = (ssp_en && fifo_nempty) ? ST_READ : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next-state values so they line up with the
  // state they describe while still coming straight from registers.
  always_ff @(posedge pclk or negedge clear) begin
    if (!clear) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      fifo_en <= 1'b0;
      sclk    <= 1'b0;
      fss     <= 1'b0;
      txd     <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bitcnt  <= bitcnt_nxt;
      fifo_en <= (state_nxt == ST_READ);
      sclk    <= serial_nxt && (half_tick ? phase : !phase);
      fss     <= (state_nxt == ST_FRAME);
      txd     <= (state_nxt == ST_SHIFT) && shreg_nxt[WIDTH-1];
      busy    <= (state_nxt != ST_IDLE);
      tx_done <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Bench for ssp_tx_ctrl: two instances (DIV=1 and DIV=3) each fed by a simple
// FIFO model, checked cycle by cycle against a timeline model of the link.
module tb_ssp_tx_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] ssp_en;
  logic [1:0] fifo_nempty;
  logic [7:0] fifo_word0, fifo_word1;
  logic [1:0] fifo_en, fifo_rw, sclk, fss, txd, busy, tx_done;

  always #5 clk = ~clk;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] rd_ptr0 = '0, wr_ptr0 = '0, rd_ptr1 = '0, wr_ptr1 = '0;

  assign fifo_nempty = {wr_ptr1 != rd_ptr1, wr_ptr0 != rd_ptr0};

  always @(posedge clk) if (fifo_en[0]) begin
    fifo_word0 <= mem0[rd_ptr0];
    rd_ptr0    <= rd_ptr0 + 4'd1;
  end
  always @(posedge clk) if (fifo_en[1]) begin
    fifo_word1 <= mem1[rd_ptr1];
    rd_ptr1    <= rd_ptr1 + 4'd1;
  end

  ssp_tx_ctrl #(.WIDTH(8), .DIV(1)) dut_d1 (
    .pclk(clk), .clear(clear), .ssp_en(ssp_en[0]), .fifo_nempty(fifo_nempty[0]),
    .fifo_word(fifo_word0), .fifo_en(fifo_en[0]), .fifo_rw(fifo_rw[0]),
    .sclk(sclk[0]), .fss(fss[0]), .txd(txd[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  ssp_tx_ctrl #(.WIDTH(8), .DIV(3)) dut_d3 (
    .pclk(clk), .clear(clear), .ssp_en(ssp_en[1]), .fifo_nempty(fifo_nempty[1]),
    .fifo_word(fifo_word1), .fifo_en(fifo_en[1]), .fifo_rw(fifo_rw[1]),
    .sclk(sclk[1]), .fss(fss[1]), .txd(txd[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] stim [8];
  logic [7:0] dec  [8];

  // {rw, fifo_en, sclk, fss, txd, busy, tx_done} at global cycle g after the
  // start edge: words occupy back-to-back slots of T cycles each.
  function automatic logic [6:0] model(input int g, input int D, input int nexp);
    int T, k, t, s, p;
    logic [7:0] w;
    logic en_e, sclk_e, fss_e, txd_e, done_e;
    T = 3 + 2 * D * 9;
    if (g < 1 || g > nexp * T) return 7'b0;
    k = (g - 1) / T;
    t = (g - 1) % T + 1;
    w = stim[k];
    en_e = (t == 1);
    done_e = (t == T);
    sclk_e = 1'b0; fss_e = 1'b0; txd_e = 1'b0;
    if (t >= 3 && t < T) begin
      s = t - 3;
      p = s / (2 * D);
      sclk_e = ((s % (2 * D)) < D);
      fss_e  = (p == 0);
      txd_e  = (p >= 1) ? w[8 - p] : 1'b0;
    end
    return {1'b0, en_e, sclk_e, fss_e, txd_e, 1'b1, done_e};
  endfunction

  function automatic logic [6:0] observe(input int d);
    return {fifo_rw[d], fifo_en[d], sclk[d], fss[d], txd[d], busy[d], tx_done[d]};
  endfunction

  task automatic push(input int d, input logic [7:0] w);
    if (d == 0) begin mem0[wr_ptr0] = w; wr_ptr0 = wr_ptr0 + 4'd1; end
    else        begin mem1[wr_ptr1] = w; wr_ptr1 = wr_ptr1 + 4'd1; end
  endtask

  task automatic flush(input int d);
    @(negedge clk);
    if (d == 0) wr_ptr0 = rd_ptr0;
    else        wr_ptr1 = rd_ptr1;
  endtask

  task automatic run_stream(input int d, input int D, input int n, input int drop_at,
                            input string name);
    int T, nexp, ndec, nbits, npulse;
    logic [7:0] acc;
    logic [6:0] o, e;
    logic prev_sclk;
    T = 3 + 2 * D * 9;
    nexp = (drop_at > 0) ? (drop_at - 1) / T + 1 : n;
    if (nexp > n) nexp = n;
    @(negedge clk);
    for (int i = 0; i < n; i++) push(d, stim[i]);
    ssp_en[d] = 1'b1;
    ndec = 0; nbits = 0; npulse = 0; acc = '0; prev_sclk = 1'b0;
    for (int g = 1; g <= nexp * T + 4; g++) begin
      @(negedge clk);
      o = observe(d);
      e = model(g, D, nexp);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: {rw,en,sclk,fss,txd,busy,done}=%b, expected %b",
                 name, g, o, e);
      end
      if (fifo_en[d] === 1'b1) npulse++;
      if (prev_sclk && sclk[d] === 1'b0 && fss[d] === 1'b0) begin
        acc = {acc[6:0], txd[d]};
        nbits++;
        if (nbits == 8) begin
          if (ndec < 8) dec[ndec] = acc;
          ndec++;
          nbits = 0;
        end
      end
      prev_sclk = (sclk[d] === 1'b1);
      if (g == drop_at) ssp_en[d] = 1'b0;
    end
    ssp_en[d] = 1'b0;
    vectors++;
    if (npulse != nexp) begin
      miscompares++;
      $display("FAIL %s fifo_en pulses: got %0d, expected %0d", name, npulse, nexp);
    end
    vectors++;
    if (ndec != nexp) begin
      miscompares++;
      $display("FAIL %s decoded word count: got %0d, expected %0d", name, ndec, nexp);
    end
    for (int k = 0; k < nexp && k < ndec && k < 8; k++) begin
      vectors++;
      if (dec[k] !== stim[k]) begin
        miscompares++;
        $display("FAIL %s decoded word %0d: got %h, expected %h", name, k, dec[k], stim[k]);
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    ssp_en = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (observe(d) !== 7'b0) begin
        miscompares++;
        $display("FAIL reset dut%0d: outputs %b, expected 0000000", d, observe(d));
      end
    end
    clear = 1'b1;
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    push(0, 8'hC3);
    ssp_en[0] = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_shift busy before clear: got %b, expected 1", busy[0]);
    end
    clear = 1'b0;
    #1;
    vectors++;
    if (observe(0) !== 7'b0) begin
      miscompares++;
      $display("FAIL async clear: outputs %b, expected 0000000", observe(0));
    end
    repeat (2) @(negedge clk);
    clear = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      vectors++;
      if (observe(0) !== 7'b0) begin
        miscompares++;
        $display("FAIL idle after clear cycle %0d: outputs %b, expected 0000000", i, observe(0));
      end
    end
    ssp_en[0] = 1'b0;
  endtask

  task automatic test_single_word();
    stim[0] = 8'h63;
    run_stream(0, 1, 1, 0, "single_63");
  endtask

  task automatic test_back_to_back();
    stim[0] = 8'h63; stim[1] = 8'h61; stim[2] = 8'h74; stim[3] = 8'h73;
    run_stream(0, 1, 4, 0, "cats");
  endtask

  task automatic test_en_drop();
    stim[0] = 8'h5A; stim[1] = 8'h3C;
    run_stream(0, 1, 2, 11, "en_drop");
    vectors++;
    if ({busy[0], fifo_nempty[0]} !== 2'b01) begin
      miscompares++;
      $display("FAIL en_drop idle with word pending: {busy,nempty}=%b, expected 01",
               {busy[0], fifo_nempty[0]});
    end
    flush(0);
  endtask

  task automatic test_div3();
    stim[0] = 8'hA5;
    run_stream(1, 3, 1, 0, "div3_a5");
  endtask

  task automatic test_random();
    int d, n, D, T, drop;
    for (int it = 0; it < 8; it++) begin
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      D = (d == 0) ? 1 : 3;
      T = 3 + 2 * D * 9;
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      drop = (n > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, T * (n - 1))) : 0;
      run_stream(d, D, n, drop, "random");
      flush(d);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_single_word();
    test_back_to_back();
    test_en_drop();
    test_div3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
